// File: rtl/pet_event_arbiter.sv
// Pet event arbiter: merges sensor and joystick events into a single
// prioritised valid/ready stream, latching events while the screen is busy
// and holding off new offers for a cooldown after each accepted event.
//
// state  | meaning
// IDLE   | no offer outstanding; grants the highest-priority pending code
// OFFER  | evt_valid high, evt_code stable, waiting for evt_ready
// COOL   | counting down the post-acceptance idle time
module pet_event_arbiter #(
    parameter int unsigned COOLDOWN = 25_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       awaking,
    input  logic       touched,
    input  logic       expecting,
    input  logic       petting,
    input  logic       pressed,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       evt_valid,
    output logic [3:0] evt_code,
    input  logic       evt_ready,
    output logic       busy,
    output logic [8:0] pending,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [8:0]       pending_q, pending_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [3:0]       evt_code_q, evt_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] lvl_in;
    logic [8:0] evt_in;
    logic [8:0] grant_oh;
    logic [8:0] grant_clr;
    logic [3:0] grant_code;
    logic [8:0] drop_hits;
    logic [3:0] drop_sum;
    logic [8:0] drop_tot;

    // Level inputs ordered by their code index (touched lowest, awaking highest).
    assign lvl_in = {awaking, expecting, petting, touched};
    assign evt_in = {lvl_in & ~prev_q, right, left, down, up, pressed};

    // Lowest set pending index wins; also its one-hot form for clearing.
    always_comb begin
        grant_oh   = pending_q & (~pending_q + 9'd1);
        grant_code = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_code = 4'(i + 1);
            end
        end
    end

    // Next state, grant and cooldown counter.
    always_comb begin
        state_d    = state_q;
        evt_code_d = evt_code_q;
        cnt_d      = cnt_q;
        grant_clr  = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 9'd0) begin
                    grant_clr  = grant_oh;
                    evt_code_d = grant_code;
                    state_d    = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready) begin
                    if (COOLDOWN == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(COOLDOWN);
                        state_d = S_COOL;
                    end
                end
            end
            S_COOL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending bits and drop counting; a new event beats a same-cycle grant clear.
    always_comb begin
        prev_d    = lvl_in;
        pending_d = (pending_q & ~grant_clr) | evt_in;
        drop_hits = evt_in & pending_q & ~grant_clr;
        drop_sum  = 4'd0;
        for (int i = 0; i < 9; i++) begin
            drop_sum = drop_sum + {3'b000, drop_hits[i]};
        end
        drop_tot   = {1'b0, drop_cnt_q} + {5'd0, drop_sum};
        drop_cnt_d = drop_tot[8] ? 8'hFF : drop_tot[7:0];
    end

    // Register update; prev keeps tracking the inputs during reset so a level
    // already high at release does not count as an event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            prev_q     <= lvl_in;
            pending_q  <= 9'd0;
            drop_cnt_q <= 8'd0;
            evt_code_q <= 4'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            evt_code_q <= evt_code_d;
            cnt_q      <= cnt_d;
        end
    end

    assign evt_valid = (state_q == S_OFFER);
    assign busy      = (state_q != S_IDLE);
    assign evt_code  = evt_code_q;
    assign pending   = pending_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pet_event_arbiter.sv
// Bench for pet_event_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a timeline model.
module tb_pet_event_arbiter;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       awaking = 1'b0, touched = 1'b0, expecting = 1'b0, petting = 1'b0;
    logic       pressed = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       busy;
    logic [8:0] pending;
    logic [7:0] drop_cnt;

    int n_tot = 0;
    int n_bad = 0;

    pet_event_arbiter #(.COOLDOWN(CD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .awaking   (awaking),
        .touched   (touched),
        .expecting (expecting),
        .petting   (petting),
        .pressed   (pressed),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .busy      (busy),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: the offered code (0 = none), the first cycle the arbiter
    // may grant again, the set of latched codes and the drop total.
    bit [8:0] m_pend;
    bit [8:0] m_ev;
    bit [3:0] m_prev;
    int       m_drops;
    int       m_offer;
    int       m_cyc = 0;
    int       m_idle_at = 0;
    int       m_grant;
    bit       m_on = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_prev    = {awaking, expecting, petting, touched};
            m_pend    = 9'd0;
            m_drops   = 0;
            m_offer   = 0;
            m_idle_at = m_cyc + 1;
            m_on      = 1'b1;
        end else begin
            m_ev[0] = pressed;
            m_ev[1] = up;
            m_ev[2] = down;
            m_ev[3] = left;
            m_ev[4] = right;
            m_ev[5] = touched   & ~m_prev[0];
            m_ev[6] = petting   & ~m_prev[1];
            m_ev[7] = expecting & ~m_prev[2];
            m_ev[8] = awaking   & ~m_prev[3];
            m_prev  = {awaking, expecting, petting, touched};
            m_grant = -1;
            if (m_offer == 0 && m_cyc >= m_idle_at && m_pend != 9'd0) begin
                for (int i = 8; i >= 0; i--) begin
                    if (m_pend[i]) m_grant = i;
                end
            end else if (m_offer != 0 && evt_ready) begin
                m_offer   = 0;
                m_idle_at = m_cyc + 1 + CD;
            end
            for (int i = 0; i < 9; i++) begin
                if (m_ev[i] && m_pend[i] && i != m_grant && m_drops < 255) m_drops++;
            end
            if (m_grant >= 0) begin
                m_pend[m_grant] = 1'b0;
                m_offer = m_grant + 1;
            end
            m_pend = m_pend | m_ev;
        end
        m_cyc++;
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("m_valid", int'(evt_valid), int'(m_offer != 0));
            chk("m_busy", int'(busy), int'(m_offer != 0 || m_cyc < m_idle_at));
            chk("m_pending", int'(pending), int'(m_pend));
            chk("m_drop_cnt", int'(drop_cnt), m_drops);
            if (m_offer != 0) chk("m_code", int'(evt_code), m_offer);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // Reset with a level already high: no event at release.
        awaking = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_pending", int'(pending), 0);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        repeat (3) tick();
        chk("rst_pending_later", int'(pending), 0);
        chk("rst_busy_later", int'(busy), 0);

        // Single up pulse with ready held high.
        evt_ready = 1'b1;
        up = 1'b1;
        tick();
        up = 1'b0;
        chk("single_pend_t1", int'(pending), 'h002);
        tick();
        chk("single_valid_t2", int'(evt_valid), 1);
        chk("single_code_t2", int'(evt_code), 2);
        chk("single_busy_t2", int'(busy), 1);
        tick();
        chk("single_valid_t3", int'(evt_valid), 0);
        for (int k = 3; k <= 6; k++) begin
            if (k > 3) tick();
            chk("single_busy_cool", int'(busy), 1);
        end
        tick();
        chk("single_busy_t7", int'(busy), 0);
        repeat (2) tick();

        // Priority: touched rise and pressed together, consumer stalled.
        evt_ready = 1'b0;
        touched = 1'b1;
        pressed = 1'b1;
        tick();
        pressed = 1'b0;
        chk("prio_pend_t1", int'(pending), 'h021);
        tick();
        chk("prio_valid_t2", int'(evt_valid), 1);
        chk("prio_code_t2", int'(evt_code), 1);
        chk("prio_pend_t2", int'(pending), 'h020);
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("prio_valid_a1", int'(evt_valid), 0);
        repeat (4) tick();
        chk("prio_valid_a5", int'(evt_valid), 0);
        tick();
        chk("prio_valid_a6", int'(evt_valid), 1);
        chk("prio_code_a6", int'(evt_code), 6);
        chk("prio_pend_a6", int'(pending), 0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat (7) tick();

        // Drop: code 3 offered and stalled, two more down pulses.
        down = 1'b1;
        tick();
        down = 1'b0;
        tick();
        chk("drop_code", int'(evt_code), 3);
        chk("drop_valid", int'(evt_valid), 1);
        down = 1'b1;
        tick();
        chk("drop_pend_first", int'(pending), 'h004);
        chk("drop_cnt_first", int'(drop_cnt), 0);
        tick();
        down = 1'b0;
        chk("drop_cnt_second", int'(drop_cnt), 1);
        chk("drop_pend_second", int'(pending), 'h004);
        evt_ready = 1'b1;
        repeat (6) tick();
        chk("drop_reoffer_valid", int'(evt_valid), 1);
        chk("drop_reoffer_code", int'(evt_code), 3);
        repeat (7) tick();

        // Same-cycle grant clear and new left event.
        left = 1'b1;
        tick();
        tick();
        left = 1'b0;
        chk("setclr_valid", int'(evt_valid), 1);
        chk("setclr_code", int'(evt_code), 4);
        chk("setclr_pend", int'(pending), 'h008);
        chk("setclr_drop", int'(drop_cnt), 1);
        repeat (6) tick();
        chk("setclr_again_valid", int'(evt_valid), 1);
        chk("setclr_again_code", int'(evt_code), 4);
        chk("setclr_again_pend", int'(pending), 0);
        repeat (7) tick();

        // Reset during cooldown with codes 6 and 8 pending.
        touched = 1'b0;
        tick();
        right = 1'b1;
        tick();
        right = 1'b0;
        tick();
        chk("rcool_code", int'(evt_code), 5);
        tick();
        touched = 1'b1;
        expecting = 1'b1;
        tick();
        chk("rcool_pend", int'(pending), 'h0A0);
        chk("rcool_busy", int'(busy), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rcool_pend_after", int'(pending), 0);
        chk("rcool_busy_after", int'(busy), 0);
        chk("rcool_valid_after", int'(evt_valid), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rcool_no_offer", int'(evt_valid), 0);
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            tick();
            pressed   = ($urandom_range(0, 15) == 0);
            up        = ($urandom_range(0, 15) == 0);
            down      = ($urandom_range(0, 15) == 0);
            left      = ($urandom_range(0, 15) == 0);
            right     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) touched   = ~touched;
            if ($urandom_range(0, 19) == 0) petting   = ~petting;
            if ($urandom_range(0, 19) == 0) expecting = ~expecting;
            if ($urandom_range(0, 19) == 0) awaking   = ~awaking;
            evt_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) != 0);
        end

        // Stalled consumer under heavy traffic drives drop_cnt to saturation.
        rst = 1'b1;
        evt_ready = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            pressed = $urandom_range(0, 1) == 1;
            up      = $urandom_range(0, 1) == 1;
            down    = $urandom_range(0, 1) == 1;
            left    = $urandom_range(0, 1) == 1;
            right   = $urandom_range(0, 1) == 1;
            touched = ~touched;
        end
        tick();
        chk("sat_drop", int'(drop_cnt), 255);
        pressed = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        evt_ready = 1'b1;
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
